// File: rtl/dg_checker.sv
`default_nettype none
// ============================================================================
// dg_checker : read-back pattern checker; regenerates the seeded pattern and
//              compares valid byte lanes, counting beats and mismatches.
//              Optional macro DG_CHK_FIRST_ERR_EN adds first-error capture.
// Revision   : 1.0
// ============================================================================
module dg_checker #(
    parameter int C_AXI_DATA_WIDTH   = 64,
    parameter int PATTERN_DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            pattern_init,
    input  logic [2:0]                      pattern_mode,
    input  logic [PATTERN_DATA_WIDTH-1:0]   pattern_word,
    input  logic [C_AXI_DATA_WIDTH-1:0]     rdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]   rdata_bvld,
    input  logic                            rdata_vld,
    input  logic                            wrd_cntr_rst,
    output logic                            msmatch_err,
    output logic [7:0]                      wrd_cntr,
    output logic [7:0]                      err_cnt,
    output logic                            armed
`ifdef DG_CHK_FIRST_ERR_EN
    ,
    output logic [7:0]                      first_err_idx,
    output logic [C_AXI_DATA_WIDTH-1:0]     first_err_data
`endif
);

    localparam int LANES  = C_AXI_DATA_WIDTH / PATTERN_DATA_WIDTH;
    localparam int NBYTES = C_AXI_DATA_WIDTH / 8;

    localparam logic [2:0] MODE_INCR = 3'd1;
    localparam logic [2:0] MODE_DECR = 3'd2;
    localparam logic [2:0] MODE_WALK = 3'd3;
    localparam logic [2:0] MODE_ALT  = 3'd4;
    localparam logic [PATTERN_DATA_WIDTH-1:0] C_ONE = PATTERN_DATA_WIDTH'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CHECK = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic [PATTERN_DATA_WIDTH-1:0]   seed_q, seed_d;
    logic [2:0]                      mode_q, mode_d;
    logic [PATTERN_DATA_WIDTH-1:0]   exp_q, exp_d;
    logic                            pend_q, pend_d;
    logic                            pmis_q, pmis_d;
    logic [7:0]                      wrd_q, wrd_d;
    logic [7:0]                      err_q, err_d;
    logic                            flag_q, flag_d;
`ifdef DG_CHK_FIRST_ERR_EN
    logic [C_AXI_DATA_WIDTH-1:0]     pdata_q, pdata_d;
    logic [7:0]                      fidx_q, fidx_d;
    logic [C_AXI_DATA_WIDTH-1:0]     fdata_q, fdata_d;
`endif

    logic                            w_accept;
    logic                            w_clear;
    logic                            w_beat_mis;
    logic [PATTERN_DATA_WIDTH-1:0]   w_exp_next;
    logic [C_AXI_DATA_WIDTH-1:0]     w_exp_rep;

    assign w_accept  = rdata_vld && (state_q == S_CHECK) && !pattern_init;
    assign w_clear   = pattern_init || wrd_cntr_rst;
    assign w_exp_rep = {LANES{exp_q}};

    always_comb begin
        w_beat_mis = 1'b0;
        for (int i = 0; i < NBYTES; i++) begin
            if (rdata_bvld[i] && (rdata[8*i +: 8] != w_exp_rep[8*i +: 8])) begin
                w_beat_mis = 1'b1;
            end
        end
    end

    // exp_q always holds the value for the current beat index; step it per beat
    always_comb begin
        case (mode_q)
            MODE_INCR: w_exp_next = exp_q + C_ONE;
            MODE_DECR: w_exp_next = exp_q - C_ONE;
            MODE_WALK: w_exp_next = {exp_q[PATTERN_DATA_WIDTH-2:0], exp_q[PATTERN_DATA_WIDTH-1]};
            MODE_ALT:  w_exp_next = (exp_q == seed_q) ? ~seed_q : seed_q;
            default:   w_exp_next = exp_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        mode_d  = mode_q;
        exp_d   = exp_q;
        wrd_d   = wrd_q;
        err_d   = err_q;
        flag_d  = flag_q;
        pend_d  = w_accept && !w_clear;
        pmis_d  = w_beat_mis;
`ifdef DG_CHK_FIRST_ERR_EN
        pdata_d = rdata;
        fidx_d  = fidx_q;
        fdata_d = fdata_q;
`endif
        if (pattern_init) begin
            state_d = S_CHECK;
            seed_d  = pattern_word;
            mode_d  = pattern_mode;
            exp_d   = pattern_word;
        end else if (w_accept) begin
            exp_d   = w_exp_next;
        end

        // A clear also discards the result still sitting in the compare stage
        if (w_clear) begin
            wrd_d  = 8'd0;
            err_d  = 8'd0;
            flag_d = 1'b0;
`ifdef DG_CHK_FIRST_ERR_EN
            fidx_d  = 8'd0;
            fdata_d = '0;
`endif
        end else if (pend_q) begin
            wrd_d = wrd_q + 8'd1;
            if (pmis_q) begin
                flag_d = 1'b1;
                if (err_q != 8'hFF) begin
                    err_d = err_q + 8'd1;
                end
`ifdef DG_CHK_FIRST_ERR_EN
                if (!flag_q) begin
                    fidx_d  = wrd_q;
                    fdata_d = pdata_q;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            seed_q  <= '0;
            mode_q  <= 3'd0;
            exp_q   <= '0;
            pend_q  <= 1'b0;
            pmis_q  <= 1'b0;
            wrd_q   <= 8'd0;
            err_q   <= 8'd0;
            flag_q  <= 1'b0;
`ifdef DG_CHK_FIRST_ERR_EN
            pdata_q <= '0;
            fidx_q  <= 8'd0;
            fdata_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            mode_q  <= mode_d;
            exp_q   <= exp_d;
            pend_q  <= pend_d;
            pmis_q  <= pmis_d;
            wrd_q   <= wrd_d;
            err_q   <= err_d;
            flag_q  <= flag_d;
`ifdef DG_CHK_FIRST_ERR_EN
            pdata_q <= pdata_d;
            fidx_q  <= fidx_d;
            fdata_q <= fdata_d;
`endif
        end
    end

    assign msmatch_err = flag_q;
    assign wrd_cntr    = wrd_q;
    assign err_cnt     = err_q;
    assign armed       = (state_q == S_CHECK);
`ifdef DG_CHK_FIRST_ERR_EN
    assign first_err_idx  = fidx_q;
    assign first_err_data = fdata_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dg_checker.sv
`default_nettype none
// ============================================================================
// tb_dg_checker : scoreboard bench for dg_checker with a beat-index based
//                 reference model; honours DG_CHK_FIRST_ERR_EN if defined.
// Revision      : 1.0
// ============================================================================
module tb_dg_checker;

    localparam int CW = 64;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pattern_init = 1'b0;
    logic [2:0]    pattern_mode = 3'd0;
    logic [PW-1:0] pattern_word = '0;
    logic [CW-1:0] rdata = '0;
    logic [7:0]    rdata_bvld = 8'd0;
    logic          rdata_vld = 1'b0;
    logic          wrd_cntr_rst = 1'b0;
    logic          msmatch_err;
    logic [7:0]    wrd_cntr;
    logic [7:0]    err_cnt;
    logic          armed;
`ifdef DG_CHK_FIRST_ERR_EN
    logic [7:0]    first_err_idx;
    logic [CW-1:0] first_err_data;
`endif

    dg_checker #(.C_AXI_DATA_WIDTH(CW), .PATTERN_DATA_WIDTH(PW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pattern_init (pattern_init),
        .pattern_mode (pattern_mode),
        .pattern_word (pattern_word),
        .rdata        (rdata),
        .rdata_bvld   (rdata_bvld),
        .rdata_vld    (rdata_vld),
        .wrd_cntr_rst (wrd_cntr_rst),
        .msmatch_err  (msmatch_err),
        .wrd_cntr     (wrd_cntr),
        .err_cnt      (err_cnt),
        .armed        (armed)
`ifdef DG_CHK_FIRST_ERR_EN
        ,
        .first_err_idx  (first_err_idx),
        .first_err_data (first_err_data)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0]    wrd;
        logic [7:0]    err;
        logic          flag;
        logic          arm;
        logic [7:0]    fidx;
        logic [CW-1:0] fdata;
    } exp_t;
    exp_t sb_q[$];

    // reference model state
    bit            m_armed;
    logic [PW-1:0] m_seed;
    logic [2:0]    m_mode;
    int            m_n;
    int            m_wrd, m_err;
    bit            m_flag;
    logic [7:0]    m_fidx;
    logic [CW-1:0] m_fdata;
    bit            p_v, p_mis;
    logic [CW-1:0] p_data;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [PW-1:0] exp_of(input logic [PW-1:0] s, input logic [2:0] md, input int n);
        logic [PW-1:0] r;
        r = s;
        case (md)
            3'd1: r = s + PW'(n);
            3'd2: r = s - PW'(n);
            3'd3: for (int i = 0; i < n % PW; i++) r = {r[PW-2:0], r[PW-1]};
            3'd4: r = (n % 2 == 1) ? ~s : s;
            default: r = s;
        endcase
        return r;
    endfunction

    function automatic bit mism(input logic [CW-1:0] d, input logic [7:0] bv, input logic [PW-1:0] x);
        logic [CW-1:0] rep;
        rep = {x, x};
        for (int i = 0; i < 8; i++)
            if (bv[i] && d[8*i +: 8] != rep[8*i +: 8]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_armed = 0; m_seed = '0; m_mode = 3'd0; m_n = 0;
        m_wrd = 0; m_err = 0; m_flag = 0; m_fidx = 8'd0; m_fdata = '0;
        p_v = 0; p_mis = 0; p_data = '0;
    endtask

    task automatic model_edge();
        bit clr, acc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        clr = pattern_init || wrd_cntr_rst;
        acc = rdata_vld && m_armed && !pattern_init;
        if (clr) begin
            m_wrd = 0; m_err = 0; m_flag = 0; m_fidx = 8'd0; m_fdata = '0;
        end else if (p_v) begin
            if (p_mis) begin
                if (!m_flag) begin
                    m_fidx  = 8'(m_wrd);
                    m_fdata = p_data;
                end
                m_flag = 1;
                if (m_err < 255) m_err++;
            end
            m_wrd = (m_wrd + 1) % 256;
        end
        p_v    = acc && !clr;
        p_mis  = acc ? mism(rdata, rdata_bvld, exp_of(m_seed, m_mode, m_n)) : 1'b0;
        p_data = rdata;
        if (acc) m_n++;
        if (pattern_init) begin
            m_armed = 1; m_seed = pattern_word; m_mode = pattern_mode; m_n = 0;
        end
    endtask

    task automatic step(input bit pi, input logic [2:0] md, input logic [PW-1:0] wd,
                        input logic [CW-1:0] d, input logic [7:0] bv, input bit v, input bit wr);
        exp_t e;
        pattern_init = pi; pattern_mode = md; pattern_word = wd;
        rdata = d; rdata_bvld = bv; rdata_vld = v; wrd_cntr_rst = wr;
        @(posedge clk);
        model_edge();
        e.wrd = 8'(m_wrd); e.err = 8'(m_err); e.flag = m_flag; e.arm = m_armed;
        e.fidx = m_fidx; e.fdata = m_fdata;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    function automatic logic [CW-1:0] good_data();
        logic [PW-1:0] x;
        x = exp_of(m_seed, m_mode, m_n);
        return {x, x};
    endfunction

    task automatic idle();
        step(0, 3'd0, '0, '0, 8'd0, 0, 0);
    endtask

    task automatic init(input logic [2:0] md, input logic [PW-1:0] wd);
        step(1, md, wd, '0, 8'd0, 0, 0);
    endtask

    task automatic beat(input logic [CW-1:0] d, input logic [7:0] bv);
        step(0, 3'd0, '0, d, bv, 1, 0);
    endtask

    // monitor: outputs are registered, one scoreboard entry per clock edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("wrd_cntr", CW'(wrd_cntr), CW'(e.wrd));
                chk("err_cnt", CW'(err_cnt), CW'(e.err));
                chk("msmatch_err", CW'(msmatch_err), CW'(e.flag));
                chk("armed", CW'(armed), CW'(e.arm));
`ifdef DG_CHK_FIRST_ERR_EN
                chk("first_err_idx", CW'(first_err_idx), CW'(e.fidx));
                chk("first_err_data", first_err_data, e.fdata);
`endif
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [CW-1:0] d;
        logic [7:0]    bv;
        model_reset();
        rst_n = 1'b0;
        @(negedge clk);
        repeat (2) idle();
        rst_n = 1'b1;

        // beats before any init are ignored
        repeat (10) step(0, 3'd0, '0, {2{32'h1234_5678}}, 8'hFF, 1, 0);

        // INCR across the 32-bit wrap
        init(3'd1, 32'hFFFF_FFFE);
        beat({2{32'hFFFF_FFFE}}, 8'hFF);
        beat({2{32'hFFFF_FFFF}}, 8'hFF);
        beat({2{32'h0000_0000}}, 8'hFF);
        beat({2{32'h0000_0001}}, 8'hFF);
        repeat (2) idle();

        // ALT with a corrupted byte 0 on beat 2, then a masked corruption
        init(3'd4, 32'hA5A5_A5A5);
        beat(good_data(), 8'hFF);
        beat(good_data(), 8'hFF);
        beat(good_data() ^ 64'hFF, 8'hFF);
        beat(good_data() ^ 64'hFF, 8'hFE);
        beat(good_data(), 8'h00);
        repeat (2) idle();

        // init with a beat in the same cycle drops the beat
        step(1, 3'd1, 32'h10, {2{32'h10}}, 8'hFF, 1, 0);
        idle();
        // clear while an error is flagged and while a bad beat is in flight
        beat(~good_data(), 8'hFF);
        beat(~good_data(), 8'hFF);
        step(0, 3'd0, '0, ~good_data(), 8'hFF, 1, 1);
        beat(good_data(), 8'hFF);
        repeat (2) idle();

        // DECR from zero, 300 good beats, then 260 bad beats
        init(3'd2, 32'h0);
        repeat (300) beat(good_data(), 8'($urandom));
        repeat (260) beat(~good_data(), 8'hFF);
        repeat (2) idle();

        // randomized traffic across all modes
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                init(3'($urandom_range(0, 7)), $urandom);
            end else begin
                d  = good_data();
                bv = 8'($urandom);
                if ($urandom_range(0, 4) == 0) d[8*$urandom_range(0, 7) +: 8] ^= 8'($urandom_range(1, 255));
                step(0, 3'd0, '0, d, bv, ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0));
            end
        end

        // asynchronous reset mid-stream
        init(3'd0, 32'hDEAD_BEEF);
        beat({2{32'h0}}, 8'hFF);
        beat({2{32'h0}}, 8'hFF);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst wrd_cntr", CW'(wrd_cntr), '0);
        chk("async_rst err_cnt", CW'(err_cnt), '0);
        chk("async_rst msmatch_err", CW'(msmatch_err), '0);
        chk("async_rst armed", CW'(armed), '0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        repeat (3) step(0, 3'd0, '0, {2{32'hDEAD_BEEF}}, 8'hFF, 1, 0);
        init(3'd3, 32'h8000_0001);
        repeat (40) beat(good_data(), 8'hFF);
        repeat (3) idle();

        @(posedge clk);
        chk("scoreboard drained", CW'(sb_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dg_checker.md
# dg_checker

Read-back pattern checker for the data-generator datapath. It sits directly downstream of the AXI read path. It consumes `rdata`/`rdata_bvld`/`rdata_vld` beats and regenerates the expected pattern from the same `pattern_word`/`pattern_mode` that seeded the generator. It compares only the valid byte lanes, counts words, and raises `msmatch_err` on the first discrepancy.

## Interface
- `C_AXI_DATA_WIDTH`, 64, read data width in bits; must be an integer multiple of `PATTERN_DATA_WIDTH`.
- `PATTERN_DATA_WIDTH`, 32, pattern lane width in bits; a multiple of 8.
- `clk` in 1: single clock; all logic rising-edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `pattern_init` in 1: one-cycle pulse; loads seed and mode and arms the checker.
- `pattern_mode` in 3: pattern select, sampled on `pattern_init`.
- `pattern_word` in PATTERN_DATA_WIDTH: seed, sampled on `pattern_init`.
- `rdata` in C_AXI_DATA_WIDTH: read beat data.
- `rdata_bvld` in C_AXI_DATA_WIDTH/8: per-byte valid; bit i covers `rdata[8i+7:8i]`.
- `rdata_vld` in 1: beat qualifier.
- `wrd_cntr_rst` in 1: synchronous clear of `wrd_cntr`, `err_cnt` and `msmatch_err`.
- `msmatch_err` out 1: sticky mismatch flag.
- `wrd_cntr` out 8: beats accepted since arm or clear.
- `err_cnt` out 8: mismatching beats; saturates at 255.
- `armed` out 1: checker is in CHECK state.

## Operation
- States: IDLE → CHECK on `pattern_init`. CHECK stays in CHECK. A new `pattern_init` in CHECK re-seeds and clears the counters. No other exits; only `rst_n` returns the checker to IDLE.
- In IDLE, `rdata_vld` is ignored: no count and no compare.
- Expected lane value `exp` (PATTERN_DATA_WIDTH bits) is replicated across all C_AXI_DATA_WIDTH/PATTERN_DATA_WIDTH lanes. `n` is the beat index since arm.
- Pattern modes:
  - 0 FIXED: `exp` = seed.
  - 1 INCR: `exp` = seed + n, modulo 2^PATTERN_DATA_WIDTH.
  - 2 DECR: `exp` = seed − n, modulo 2^PATTERN_DATA_WIDTH.
  - 3 WALK: `exp` = seed rotated left by n mod PATTERN_DATA_WIDTH.
  - 4 ALT: `exp` = seed on even n, ~seed on odd n.
  - 5–7: reserved; behave as FIXED.
- Beat accepted = `rdata_vld` && CHECK && !`pattern_init`.
- On every accepted beat: `exp` advances, and `wrd_cntr` increments, wrapping 255→0.
- A beat mismatches if any byte with `rdata_bvld`=1 differs from `exp`. A beat with all byte-valids 0 is counted and advances `exp`, but never mismatches.
- On mismatch: `msmatch_err` sets and stays set, and `err_cnt` increments, saturating at 255.
- `pattern_init` clears `wrd_cntr`, `err_cnt` and `msmatch_err`, and resets n to 0.
- `wrd_cntr_rst` clears `wrd_cntr`, `err_cnt` and `msmatch_err` but does not touch n or the seed.

## Timing
- Reset values: `msmatch_err`=0, `wrd_cntr`=0, `err_cnt`=0, `armed`=0. Internal state returns to IDLE, seed to 0, mode to 0.
- `armed` rises the cycle after the `pattern_init` edge.
- The first beat can be accepted the cycle after `pattern_init`.
- Compare is a single register stage: the beat is accepted at edge k, and `wrd_cntr`, `err_cnt` and `msmatch_err` reflect it after edge k+1 (one-cycle latency).
- Back-to-back beats are accepted every cycle; there is no backpressure.
- `pattern_init` together with `rdata_vld`: init wins; the beat is dropped and not counted.
- `wrd_cntr_rst` together with an accepted beat: the beat is still compared and `exp` advances. Counters and flag end at 0, ignoring that beat.
- A clear issued while the pipelined result of a prior beat is in flight also discards that result.
- Asserting `rst_n` low mid-stream forces all outputs to reset values immediately. A new `pattern_init` is required before checking resumes.

## Configuration
- `DG_CHK_FIRST_ERR_EN` defined: adds output `first_err_idx` (8 bits) and output `first_err_data` (C_AXI_DATA_WIDTH bits).
  - Both capture `wrd_cntr` and `rdata` of the first mismatching beat after arm or clear.
  - Both are held until `pattern_init`, `wrd_cntr_rst` or reset, and read 0 otherwise.
  - Capture becomes visible with the same one-cycle latency as `msmatch_err`.
- `DG_CHK_FIRST_ERR_EN` undefined: these ports and their registers do not exist; all other behaviour is identical.

## Test plan
- Reset, then drive `rdata_vld`=1 with no init for 10 cycles → `wrd_cntr`=0, `armed`=0, `msmatch_err`=0.
- Init with mode 1, seed 32'hFFFF_FFFE; send 4 full beats 64'hFFFFFFFE_FFFFFFFE, ...FFFF_FFFF, 0000_0000, 0000_0001 in both lanes → `wrd_cntr`=4, `msmatch_err`=0; checks wrap.
- Init with mode 4, seed 32'hA5A5_A5A5; corrupt byte 0 of beat 2 (its `rdata_bvld`=8'hFF) → `msmatch_err`=1 two edges after beat 2, `err_cnt`=1. With the macro defined: `first_err_idx`=2.
- Repeat the corrupted beat with `rdata_bvld`=8'hFE → no error; `wrd_cntr` increments.
- Assert `pattern_init` and `rdata_vld` in the same cycle → beat dropped, `wrd_cntr`=0. Assert `wrd_cntr_rst` during an error → flag and counters read 0, and the next good beat passes.
- Mode 2, seed 0: after 300 beats → `wrd_cntr`=44 (300 mod 256) and no error. Inject 260 mismatches → `err_cnt` saturates at 255.
